// File: rtl/neo_pkg.sv
// Shared definitions for the NeoPixel rainbow-fade frame sequencer.
// Holds the sequencer state encoding, the GRB pixel and 5:5:5 ROM field
// positions, and the colour expansion helpers.
package neo_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StRead,
    StSend,
    StLatch
  } state_e;

  // Output pixel layout: {G, R, B}, 8 bits each.
  localparam int unsigned GrbGLsb = 16;
  localparam int unsigned GrbRLsb = 8;
  localparam int unsigned GrbBLsb = 0;

  // ROM word layout: bit 15 unused, then G, R, B at 5 bits each.
  localparam int unsigned RomGLsb = 10;
  localparam int unsigned RomRLsb = 5;
  localparam int unsigned RomBLsb = 0;

  // Replicating the top bits into the low bits maps 5'h1F to 8'hFF exactly.
  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  function automatic logic [23:0] rom_to_grb(input logic [15:0] w, input logic [2:0] shift);
    logic [23:0] p;
    p = '0;
    p[GrbGLsb +: 8] = expand5(w[RomGLsb +: 5]) >> shift;
    p[GrbRLsb +: 8] = expand5(w[RomRLsb +: 5]) >> shift;
    p[GrbBLsb +: 8] = expand5(w[RomBLsb +: 5]) >> shift;
    return p;
  endfunction

endpackage

// File: rtl/neo_frame_tick.sv
// Frame pacing divider.
// Counts 0..FRAME_DIV-1 while enable is high and raises tick for one cycle at
// the terminal count; holds at 0 while enable is low.
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high
//   enable - run the divider
//   tick   - one-cycle frame tick
module neo_frame_tick #(
  parameter int unsigned FRAME_DIV = 400000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = $clog2(FRAME_DIV);
  localparam logic [CW-1:0] CntLast = CW'(FRAME_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || (cnt_q == CntLast)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && (cnt_q == CntLast);

endmodule

// File: rtl/neo_fade_sequencer.sv
// Frame sequencer for the NeoPixel rainbow-fade path.
// Once per frame tick, walks NUM_PIXELS ROM addresses starting at a rotating
// base (stride PIX_STEP, 8-bit wrap), expands each 5:5:5 word to 24-bit GRB,
// hands pixels to the serializer over valid/ready, then holds an idle latch
// gap of LATCH_CYCLES before strobing frame_done and advancing the base.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   enable             - run frames while high
//   brightness[2:0]    - per-channel right shift, sampled when the ROM word is read
//   rom_addr[7:0]      - ROM read address (registered-read ROM, 1-cycle latency)
//   rom_data[15:0]     - ROM read data
//   pix_data[23:0]     - {G,R,B} pixel
//   pix_valid          - pix_data valid; held until pix_ready
//   pix_ready          - serializer accepts pix_data
//   frame_done         - one-cycle strobe at the end of the latch gap
//   overrun            - sticky: a tick arrived while a frame was in flight
module neo_fade_sequencer
  import neo_pkg::*;
#(
  parameter int unsigned NUM_PIXELS   = 8,
  parameter int unsigned PIX_STEP     = 32,
  parameter int unsigned FRAME_DIV    = 400000,
  parameter int unsigned LATCH_CYCLES = 800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  brightness,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        frame_done,
  output logic        overrun
);

  localparam int unsigned LW = $clog2(LATCH_CYCLES) + 1;
  localparam logic [LW-1:0] LatchLast = LW'(LATCH_CYCLES - 1);
  localparam logic [7:0] PixLast = 8'(NUM_PIXELS - 1);
  localparam logic [7:0] Step    = 8'(PIX_STEP);

  logic tick;

  state_e        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    count_q, count_d;
  logic [7:0]    base_q, base_d;
  logic [LW-1:0] latch_q, latch_d;
  logic [23:0]   pix_data_q, pix_data_d;
  logic          pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic          frame_done_q, frame_done_d;

  neo_frame_tick #(
    .FRAME_DIV (FRAME_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    base_d       = base_q;
    latch_d      = latch_q;
    pix_data_d   = pix_data_q;
    pending_d    = pending_q;
    overrun_d    = overrun_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable && (tick || pending_q)) begin
          addr_d    = base_q;
          count_d   = '0;
          pending_d = 1'b0;
          state_d   = StAddr;
        end
      end
      StAddr: begin
        state_d = StRead;
      end
      StRead: begin
        // ROM data for addr_q is valid now; brightness is frozen into the pixel here.
        pix_data_d = rom_to_grb(rom_data, brightness);
        state_d    = StSend;
      end
      StSend: begin
        if (pix_ready) begin
          if (count_q == PixLast) begin
            latch_d = '0;
            state_d = StLatch;
          end else begin
            count_d = count_q + 8'd1;
            addr_d  = addr_q + Step;
            state_d = StAddr;
          end
        end
      end
      StLatch: begin
        if (latch_q == LatchLast) begin
          frame_done_d = 1'b1;
          base_d       = base_q + 8'd1;
          state_d      = StIdle;
        end else begin
          latch_d = latch_q + LW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Ticks landing mid-frame collapse into a single pending start.
    if (tick && (state_q != StIdle)) begin
      pending_d = 1'b1;
      overrun_d = 1'b1;
    end
    if (!enable) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      count_q      <= '0;
      base_q       <= '0;
      latch_q      <= '0;
      pix_data_q   <= '0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      base_q       <= base_d;
      latch_q      <= latch_d;
      pix_data_q   <= pix_data_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
    end
  end

  // addr_q only moves on acceptance, so it stays stable from ADDR through SEND.
  assign rom_addr   = addr_q;
  assign pix_data   = pix_data_q;
  assign pix_valid  = (state_q == StSend);
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_neo_fade_sequencer.sv
// Scoreboard bench for neo_fade_sequencer: the stimulus process queues the
// expected pixel stream per frame from a behavioural model; an independent
// monitor pops and compares on every transfer.
module tb_neo_fade_sequencer;

  localparam int NP   = 4;
  localparam int STEP = 32;
  localparam int FD   = 60;
  localparam int LC   = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  brightness;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        frame_done;
  logic        overrun;

  always #5 clk = ~clk;

  neo_fade_sequencer #(
    .NUM_PIXELS   (NP),
    .PIX_STEP     (STEP),
    .FRAME_DIV    (FD),
    .LATCH_CYCLES (LC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .brightness (brightness),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  // Registered-read ROM model.
  logic [15:0] rom [256];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  addr;
    logic [23:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   xfer_total = 0;
  int   done_count = 0;
  int   last_accept_cyc = -1000;
  int   en_cyc = 0;
  int   fv_cyc[int];
  int   done_cyc[int];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference pixel: each 5-bit level scaled to 8 bits as c*8 + c/4, then dimmed.
  function automatic logic [23:0] ref_pix(input logic [15:0] w, input int sh);
    int c[3];
    int o[3];
    c[0] = int'(w[14:10]);
    c[1] = int'(w[9:5]);
    c[2] = int'(w[4:0]);
    for (int j = 0; j < 3; j++) o[j] = (c[j] * 8 + c[j] / 4) >> sh;
    return {8'(o[0]), 8'(o[1]), 8'(o[2])};
  endfunction

  // Frame f (counted from reset) reads address (f + i*STEP) mod 256 for pixel i.
  task automatic push_frame(input int f, input int b);
    exp_t e;
    int a;
    for (int i = 0; i < NP; i++) begin
      a = (f + i * STEP) % 256;
      e.addr = 8'(a);
      e.data = ref_pix(rom[a], b);
      exp_q.push_back(e);
    end
  endtask

  // Ticks occur at cycles en_cyc - 1 + k*FD, k >= 1.
  function automatic int next_tick(input int x);
    int k;
    k = (x - en_cyc + 1 + FD - 1) / FD;
    if (k < 1) k = 1;
    return en_cyc - 1 + k * FD;
  endfunction

  function automatic int get_fv(input int i);
    return fv_cyc.exists(i) ? fv_cyc[i] : -1;
  endfunction

  function automatic int get_done(input int i);
    return done_cyc.exists(i) ? done_cyc[i] : -1;
  endfunction

  task automatic wait_frames(input int n, input int bound);
    for (int k = 0; k < bound && done_count < n; k++) begin
      @(posedge clk);
      #1;
    end
    chk($sformatf("frame_done count reaches %0d", n), done_count, n);
  endtask

  task automatic wait_xfers(input int n, input int bound);
    for (int k = 0; k < bound && xfer_total < n; k++) begin
      @(posedge clk);
      #1;
    end
    chk($sformatf("transfer count reaches %0d", n), xfer_total, n);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_reset = 1'b1;
  logic [23:0] prev_data;
  logic [7:0]  prev_addr;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (prev_valid && !prev_ready && !prev_reset) begin
      chk("valid held under backpressure", pix_valid, 1);
      chk("pix_data held under backpressure", pix_data, prev_data);
      chk("rom_addr held under backpressure", rom_addr, prev_addr);
    end
    if (pix_valid === 1'b1 && !prev_valid && (xfer_total % NP == 0)) begin
      fv_cyc[xfer_total / NP] = cyc;
    end
    if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected pixel: got addr %0d data %06h, expected none", rom_addr,
                 pix_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pixel address", rom_addr, mon_e.addr);
        chk("pixel data", pix_data, mon_e.data);
      end
      xfer_total++;
      last_accept_cyc = cyc;
    end
    if (frame_done === 1'b1) begin
      chk("latch gap", cyc - last_accept_cyc, LC + 1);
      chk("frame_done after full frame", xfer_total, (done_count + 1) * NP);
      done_cyc[done_count] = cyc;
      done_count++;
    end
    prev_valid = (pix_valid === 1'b1);
    prev_ready = (pix_ready === 1'b1);
    prev_reset = reset;
    prev_data  = pix_data;
    prev_addr  = rom_addr;
  end

  int b;
  int t;
  int d2;

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    brightness = 3'd0;
    pix_ready  = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    rom[0]  = 16'h7FFF;
    rom[32] = 16'h0421;
    rom[33] = 16'h0421;

    repeat (3) @(posedge clk);
    #1;
    chk("reset rom_addr", rom_addr, 0);
    chk("reset pix_data", pix_data, 0);
    chk("reset pix_valid", pix_valid, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset overrun", overrun, 0);
    reset = 1'b0;

    // First frames: full brightness, then brightness 3.
    push_frame(0, 0);
    enable = 1'b1;
    en_cyc = cyc;
    wait_frames(1, 200);
    chk("tick to first pix_valid", get_fv(0), en_cyc + FD - 1 + 3);
    brightness = 3'd3;
    push_frame(1, 3);
    wait_frames(2, 200);
    chk("frame start period", get_fv(1) - get_fv(0), FD);

    // Backpressure on pixel 2 of frame 2; brightness wiggles while held.
    brightness = 3'd1;
    push_frame(2, 1);
    wait_xfers(2 * NP + 2, 200);
    pix_ready = 1'b0;
    for (int k = 0; k < 10 && !pix_valid; k++) begin
      @(posedge clk);
      #1;
    end
    repeat (10) begin
      brightness = 3'($urandom);
      @(posedge clk);
      #1;
    end
    chk("no transfer while stalled", xfer_total, 2 * NP + 2);
    brightness = 3'd1;
    pix_ready  = 1'b1;
    wait_frames(3, 200);

    // Run through base 250 and the 255 -> 0 wrap with random brightness.
    for (int f = 3; f <= 257; f++) begin
      b = int'($urandom_range(0, 7));
      brightness = 3'(b);
      push_frame(f, b);
      wait_frames(f + 1, 200);
    end
    chk("overrun clear with relaxed pacing", overrun, 0);

    // Overrun: stall the serializer across several ticks.
    pix_ready = 1'b0;
    push_frame(258, b);
    push_frame(259, b);
    push_frame(260, b);
    repeat (200) @(posedge clk);
    #1;
    chk("overrun set", overrun, 1);
    chk("no transfer while serializer stalled", xfer_total, 258 * NP);
    pix_ready = 1'b1;
    wait_frames(261, 400);
    chk("pending frame starts on return to idle", get_fv(259), get_done(258) + 3);
    t  = next_tick(get_done(258) + 1);
    d2 = get_done(259);
    chk("extra ticks dropped", get_fv(260), ((t > d2) ? t : d2) + 3);
    chk("overrun sticky", overrun, 1);

    // Random backpressure.
    for (int f = 261; f <= 270; f++) push_frame(f, b);
    for (int k = 0; k < 3000 && done_count < 271; k++) begin
      pix_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    chk("random backpressure frames complete", done_count, 271);
    pix_ready = 1'b1;

    // Enable falls mid-frame: frame finishes, nothing further starts.
    push_frame(271, b);
    wait_xfers(271 * NP + 1, 300);
    enable = 1'b0;
    wait_frames(272, 300);
    repeat (150) @(posedge clk);
    #1;
    chk("no frame after enable low", xfer_total, 272 * NP);
    chk("no frame_done after enable low", done_count, 272);
    chk("scoreboard drained", exp_q.size(), 0);

    // Reset while a pixel is held in SEND.
    enable = 1'b1;
    push_frame(272, b);
    wait_xfers(272 * NP + 1, 300);
    pix_ready = 1'b0;
    for (int k = 0; k < 10 && !pix_valid; k++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("pixel held before reset", pix_valid, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset mid-frame pix_valid", pix_valid, 0);
    chk("reset mid-frame rom_addr", rom_addr, 0);
    chk("reset mid-frame pix_data", pix_data, 0);
    chk("reset mid-frame overrun", overrun, 0);
    reset = 1'b0;
    en_cyc = cyc;
    exp_q.delete();
    xfer_total = 0;
    done_count = 0;
    fv_cyc.delete();
    done_cyc.delete();
    last_accept_cyc = -1000;
    pix_ready  = 1'b1;
    brightness = 3'd0;
    push_frame(0, 0);
    wait_frames(1, 200);
    chk("restart tick to first pix_valid", get_fv(0), en_cyc + FD - 1 + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
